// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by the in-order writeback and a long-latency unit.
// Long-latency results queue in a small FIFO; a pending scoreboard drives the decode stall.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_wren_i,
    input  logic [4:0]  pipe_addr_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_addr_i,
    input  logic [31:0] lu_data_i,
    input  logic        issue_i,
    input  logic [4:0]  issue_addr_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    output logic        stall_o,
    output logic        rd_wren_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          rd_wren_q, rd_wren_d, rd_lu_q, rd_lu_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic push, pop, pipe_win, fifo_empty, starve;

    assign lu_ready_o = !rst_i && (count_q < DEPTH_C);
    // x0 results complete the handshake but never occupy a slot
    assign push       = lu_valid_i && lu_ready_o && (lu_addr_i != 5'd0);
    assign pipe_win   = pipe_wren_i && (pipe_addr_i != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign pop        = !pipe_win && !fifo_empty;
    assign starve     = (starve_q >= STARVE_C);

    assign stall_o   = pending_q[dec_rs1_i] | pending_q[dec_rs2_i] | pending_q[dec_rd_i] | starve;
    assign rd_wren_o = rd_wren_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        pending_d = pending_q;
        rd_wren_d = 1'b0;
        rd_lu_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (pop && !push) count_d = count_q - (AW + 1)'(1);

        if (pipe_win) begin
            rd_wren_d = 1'b1;
            rd_addr_d = pipe_addr_i;
            rd_data_d = pipe_data_i;
        end else if (pop) begin
            rd_wren_d = 1'b1;
            rd_lu_d   = 1'b1;
            rd_addr_d = fifo_addr_q[rd_ptr_q];
            rd_data_d = fifo_data_q[rd_ptr_q];
        end

        // clear first so a same-cycle re-issue of the same register keeps it pending
        if (rd_wren_q && rd_lu_q) pending_d[rd_addr_q] = 1'b0;
        if (issue_i)              pending_d[issue_addr_i] = 1'b1;
        pending_d[0] = 1'b0;

        if (pop || fifo_empty)       starve_d = '0;
        else if (starve_q < STARVE_C) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
            rd_wren_q <= 1'b0;
            rd_lu_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            rd_wren_q <= rd_wren_d;
            rd_lu_q   <= rd_lu_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= lu_addr_i;
            fifo_data_q[wr_ptr_q] <= lu_data_i;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, starvation sequence, then random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_wren_i;
    logic [4:0]  pipe_addr_i;
    logic [31:0] pipe_data_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_addr_i;
    logic [31:0] lu_data_i;
    logic        issue_i;
    logic [4:0]  issue_addr_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic        stall_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_wren_i(pipe_wren_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
        .issue_i(issue_i), .issue_addr_i(issue_addr_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
        .stall_o(stall_o), .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    bit [4:0]  mq_a[$];
    bit [31:0] mq_d[$];
    bit [31:0] m_pend;
    int        m_starve;
    bit        m_wren, m_lu, m_zero;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    logic      s_ready, s_stall;

    typedef struct {
        bit pw; bit [4:0] pa; bit [31:0] pd;
        bit lv; bit [4:0] la; bit [31:0] ld;
        bit is; bit [4:0] ia;
        bit [4:0] r1; bit [4:0] r2; bit [4:0] rd;
        bit e_stall; bit e_ready; bit e_wren; bit [4:0] e_addr; bit [31:0] e_data;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !rst_i && (mq_a.size() < DEPTH);
    endfunction

    function automatic bit m_stall();
        return m_pend[dec_rs1_i] | m_pend[dec_rs2_i] | m_pend[dec_rd_i] | (m_starve >= STARVE_MAX);
    endfunction

    task automatic model_update();
        bit pw, pop_, rdy;
        if (rst_i) begin
            mq_a.delete(); mq_d.delete();
            m_pend = '0; m_starve = 0;
            m_wren = 0; m_lu = 0; m_addr = '0; m_data = '0; m_zero = 1;
            return;
        end
        m_zero = 0;
        rdy  = mq_a.size() < DEPTH;
        pw   = pipe_wren_i && (pipe_addr_i != 0);
        pop_ = !pw && (mq_a.size() > 0);
        if (m_wren && m_lu) m_pend[m_addr] = 1'b0;
        if (issue_i && issue_addr_i != 0) m_pend[issue_addr_i] = 1'b1;
        if (pop_ || mq_a.size() == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (pw) begin
            m_wren = 1; m_lu = 0; m_addr = pipe_addr_i; m_data = pipe_data_i;
        end else if (pop_) begin
            m_wren = 1; m_lu = 1; m_addr = mq_a.pop_front(); m_data = mq_d.pop_front();
        end else begin
            m_wren = 0; m_lu = 0;
        end
        if (rdy && lu_valid_i && lu_addr_i != 0) begin
            mq_a.push_back(lu_addr_i);
            mq_d.push_back(lu_data_i);
        end
    endtask

    // inputs must already be driven; returns 2 time units after the edge
    task automatic cyc();
        #1;
        s_ready = lu_ready_o;
        s_stall = stall_o;
        chk("ready", {31'd0, lu_ready_o}, {31'd0, m_ready()});
        chk("stall", {31'd0, stall_o}, {31'd0, m_stall()});
        @(posedge clk_i);
        model_update();
        #2;
        chk("rd_wren", {31'd0, rd_wren_o}, {31'd0, m_wren});
        if (m_wren || m_zero) begin
            chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, m_addr});
            chk("rd_data", rd_data_o, m_data);
        end
    endtask

    task automatic idle_inputs();
        pipe_wren_i = 0; pipe_addr_i = 0; pipe_data_i = 0;
        lu_valid_i = 0; lu_addr_i = 0; lu_data_i = 0;
        issue_i = 0; issue_addr_i = 0;
        dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0;
    endtask

    initial begin
        tbl[0]  = '{0,0,0, 0,0,0, 1,5, 5,0,0, 0,1,0,0,0};
        tbl[1]  = '{0,0,0, 1,5,32'hDEADBEEF, 0,0, 5,0,0, 1,1,0,0,0};
        tbl[2]  = '{0,0,0, 0,0,0, 0,0, 5,0,0, 1,1,1,5,32'hDEADBEEF};
        tbl[3]  = '{0,0,0, 0,0,0, 0,0, 5,0,0, 1,1,0,0,0};
        tbl[4]  = '{0,0,0, 0,0,0, 0,0, 5,0,0, 0,1,0,0,0};
        tbl[5]  = '{1,3,32'h11, 1,7,32'h22, 0,0, 0,0,0, 0,1,1,3,32'h11};
        tbl[6]  = '{0,0,0, 0,0,0, 0,0, 0,0,0, 0,1,1,7,32'h22};
        tbl[7]  = '{0,0,0, 0,0,0, 0,0, 0,0,0, 0,1,0,0,0};
        tbl[8]  = '{0,0,0, 1,4,32'h44, 0,0, 0,0,0, 0,1,0,0,0};
        tbl[9]  = '{1,0,32'h99, 1,0,32'h55, 1,0, 0,0,0, 0,1,1,4,32'h44};
        tbl[10] = '{0,0,0, 0,0,0, 0,0, 0,0,0, 0,1,0,0,0};
        tbl[11] = '{0,0,0, 0,0,0, 1,9, 0,9,0, 0,1,0,0,0};
        tbl[12] = '{0,0,0, 1,9,32'h99, 0,0, 0,9,0, 1,1,0,0,0};
        tbl[13] = '{0,0,0, 0,0,0, 0,0, 0,9,0, 1,1,1,9,32'h99};
        tbl[14] = '{0,0,0, 0,0,0, 1,9, 0,9,0, 1,1,0,0,0};
        tbl[15] = '{0,0,0, 0,0,0, 0,0, 0,9,0, 1,1,0,0,0};

        // reset held with a result offered: nothing may be accepted
        idle_inputs();
        rst_i = 1; lu_valid_i = 1; lu_addr_i = 5'd3; lu_data_i = 32'hABCD;
        @(posedge clk_i);
        model_update();
        #2;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_ready", {31'd0, s_ready}, 32'd0);
            chk("rst_stall", {31'd0, s_stall}, 32'd0);
        end
        rst_i = 0; lu_valid_i = 0;
        cyc();
        chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
        chk("post_rst_nopush", {31'd0, rd_wren_o}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            pipe_wren_i = tbl[i].pw; pipe_addr_i = tbl[i].pa; pipe_data_i = tbl[i].pd;
            lu_valid_i = tbl[i].lv; lu_addr_i = tbl[i].la; lu_data_i = tbl[i].ld;
            issue_i = tbl[i].is; issue_addr_i = tbl[i].ia;
            dec_rs1_i = tbl[i].r1; dec_rs2_i = tbl[i].r2; dec_rd_i = tbl[i].rd;
            cyc();
            chk($sformatf("vec%0d_stall", i), {31'd0, s_stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("vec%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].e_ready});
            chk($sformatf("vec%0d_wren", i), {31'd0, rd_wren_o}, {31'd0, tbl[i].e_wren});
            if (tbl[i].e_wren) begin
                chk($sformatf("vec%0d_addr", i), {27'd0, rd_addr_o}, {27'd0, tbl[i].e_addr});
                chk($sformatf("vec%0d_data", i), rd_data_o, tbl[i].e_data);
            end
        end

        // full FIFO under continuous pipeline writes, then starvation stall
        idle_inputs();
        pipe_wren_i = 1; pipe_addr_i = 5'd1; lu_valid_i = 1;
        for (int k = 0; k < 10; k++) begin
            pipe_data_i = 32'h100 + k;
            lu_addr_i = (k == 0) ? 5'd10 : (k == 1) ? 5'd11 : 5'd12;
            lu_data_i = 32'hA0 + lu_addr_i;
            cyc();
            chk($sformatf("full_ready_c%0d", k), {31'd0, s_ready}, {31'd0, k < 2});
            chk($sformatf("starve_c%0d", k), {31'd0, s_stall}, {31'd0, k >= 9});
        end
        pipe_wren_i = 0;
        cyc();
        chk("bubble_stall_pre", {31'd0, s_stall}, 32'd1);
        chk("bubble_pop_addr", {27'd0, rd_addr_o}, 32'd10);
        cyc();
        chk("bubble_stall_clr", {31'd0, s_stall}, 32'd0);
        chk("bubble_ready", {31'd0, s_ready}, 32'd1);
        lu_valid_i = 0;
        for (int k = 0; k < 4; k++) cyc();

        // random traffic against the reference model
        rst_i = 1; idle_inputs();
        cyc();
        rst_i = 0;
        for (int n = 0; n < 3000; n++) begin
            pipe_wren_i  = ($urandom_range(0, 99) < 45);
            pipe_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pipe_data_i  = $urandom;
            lu_valid_i   = ($urandom_range(0, 99) < 40);
            lu_addr_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lu_data_i    = $urandom;
            issue_i      = ($urandom_range(0, 99) < 30);
            issue_addr_i = 5'($urandom);
            dec_rs1_i    = 5'($urandom);
            dec_rs2_i    = 5'($urandom);
            dec_rd_i     = 5'($urandom);
            rst_i        = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst_i = 0; idle_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
